// File: rtl/cache_response_generator.sv
// Return path of the cache request generator: records requestor tags in order, pairs them with
// in-order cache read responses, buffers the pairs and delivers them to the owning requestor with a credit pulse.
module cache_response_generator #(
  parameter int unsigned NUM_MEMORY_REQUESTOR = 2,
  parameter int unsigned ID_WIDTH             = $clog2(NUM_MEMORY_REQUESTOR),
  parameter int unsigned DATA_WIDTH           = 512,
  parameter int unsigned TAG_FIFO_DEPTH       = 16,
  parameter int unsigned RESP_FIFO_DEPTH      = 16
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst_n,
  input  logic                            req_issue_valid,
  input  logic [ID_WIDTH-1:0]             req_issue_id,
  input  logic                            cache_resp_valid,
  input  logic [DATA_WIDTH-1:0]           cache_resp_rdata,
  output logic                            cache_resp_ready,
  output logic [NUM_MEMORY_REQUESTOR-1:0] mem_resp_valid,
  output logic [DATA_WIDTH-1:0]           mem_resp_rdata,
  input  logic [NUM_MEMORY_REQUESTOR-1:0] mem_resp_ready,
  output logic                            resp_credit,
  output logic                            tag_fifo_full,
  output logic                            resp_fifo_empty,
  output logic                            err_overflow,
  output logic                            err_orphan
);

  localparam int unsigned NR  = NUM_MEMORY_REQUESTOR;
  localparam int unsigned TCW = $clog2(TAG_FIFO_DEPTH + 1);
  localparam int unsigned TPW = $clog2(TAG_FIFO_DEPTH);
  localparam int unsigned RCW = $clog2(RESP_FIFO_DEPTH + 1);
  localparam int unsigned RPW = $clog2(RESP_FIFO_DEPTH);

  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;

  // ---------------------------------------------------------------- tag FIFO
  logic [ID_WIDTH-1:0] tag_mem [TAG_FIFO_DEPTH];
  logic [TPW-1:0]      tag_wptr;
  logic [TPW-1:0]      tag_rptr;
  logic [TCW-1:0]      tag_count;
  logic [TCW-1:0]      tag_count_nxt;
  logic                tag_push_c;
  logic                tag_pop_c;
  logic                accept_c;
  logic                orphan_c;

  assign accept_c      = cache_resp_valid & cache_resp_ready;
  assign tag_push_c    = req_issue_valid & ~tag_fifo_full;
  assign tag_pop_c     = accept_c & (tag_count != '0);
  assign orphan_c      = accept_c & (tag_count == '0);
  assign tag_count_nxt = tag_count + TCW'(tag_push_c) - TCW'(tag_pop_c);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      tag_wptr  <= '0;
      tag_rptr  <= '0;
      tag_count <= '0;
    end else begin
      if (tag_push_c) tag_wptr <= tag_wptr + TPW'(1);
      if (tag_pop_c)  tag_rptr <= tag_rptr + TPW'(1);
      tag_count <= tag_count_nxt;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (tag_push_c) tag_mem[tag_wptr] <= req_issue_id;
  end

  // ----------------------------------------------------------- response FIFO
  logic [ID_WIDTH-1:0]   resp_id_mem   [RESP_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] resp_data_mem [RESP_FIFO_DEPTH];
  logic [RPW-1:0]        resp_wptr;
  logic [RPW-1:0]        resp_rptr;
  logic [RCW-1:0]        resp_count;
  logic [RCW-1:0]        resp_count_nxt;
  logic                  resp_pop_c;
  logic [ID_WIDTH-1:0]   head_id_c;
  logic [DATA_WIDTH-1:0] head_data_c;

  assign head_id_c      = resp_id_mem[resp_rptr];
  assign head_data_c    = resp_data_mem[resp_rptr];
  assign resp_count_nxt = resp_count + RCW'(tag_pop_c) - RCW'(resp_pop_c);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      resp_wptr  <= '0;
      resp_rptr  <= '0;
      resp_count <= '0;
    end else begin
      if (tag_pop_c)  resp_wptr <= resp_wptr + RPW'(1);
      if (resp_pop_c) resp_rptr <= resp_rptr + RPW'(1);
      resp_count <= resp_count_nxt;
    end
  end

  // Each written response carries the tag popped in the same cycle.
  always_ff @(posedge ap_clk) begin
    if (tag_pop_c) begin
      resp_id_mem[resp_wptr]   <= tag_mem[tag_rptr];
      resp_data_mem[resp_wptr] <= cache_resp_rdata;
    end
  end

  // ------------------------------------------------------------- output FSM
  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [ID_WIDTH-1:0] out_id;
  logic [NR-1:0]       valid_nxt;
  logic                credit_nxt;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= S_RESET;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    resp_pop_c = 1'b0;
    credit_nxt = 1'b0;
    valid_nxt  = mem_resp_valid;
    case (state)
      S_RESET: state_nxt = S_IDLE;
      S_IDLE: begin
        if (resp_count != '0) begin
          resp_pop_c = 1'b1;
          valid_nxt  = NR'(1) << head_id_c;
          state_nxt  = S_SEND;
        end
      end
      S_SEND: begin
        // Only the owning requestor's ready completes the transfer.
        if (mem_resp_ready[out_id]) begin
          credit_nxt = 1'b1;
          if (resp_count != '0) begin
            resp_pop_c = 1'b1;
            valid_nxt  = NR'(1) << head_id_c;
          end else begin
            valid_nxt  = '0;
            state_nxt  = S_IDLE;
          end
        end
      end
      default: begin
        valid_nxt = '0;
        state_nxt = S_RESET;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_id         <= '0;
      mem_resp_valid <= '0;
      mem_resp_rdata <= '0;
      resp_credit    <= 1'b0;
    end else begin
      if (resp_pop_c) begin
        out_id         <= head_id_c;
        mem_resp_rdata <= head_data_c;
      end
      mem_resp_valid <= valid_nxt;
      resp_credit    <= credit_nxt;
    end
  end

  // Status flags track next-cycle occupancy; ready stays low through the RESET state.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cache_resp_ready <= 1'b0;
      tag_fifo_full    <= 1'b0;
      resp_fifo_empty  <= 1'b1;
      err_overflow     <= 1'b0;
      err_orphan       <= 1'b0;
    end else begin
      cache_resp_ready <= (state != S_RESET) && (resp_count_nxt != RCW'(RESP_FIFO_DEPTH));
      tag_fifo_full    <= (tag_count_nxt == TCW'(TAG_FIFO_DEPTH));
      resp_fifo_empty  <= (resp_count_nxt == '0);
      err_overflow     <= err_overflow | (req_issue_valid & tag_fifo_full);
      err_orphan       <= err_orphan | orphan_c;
    end
  end

endmodule

// File: tb/tb_cache_response_generator.sv
// Directed bench for cache_response_generator: cycle table for the basic path, scoreboard-checked
// sequences for stall, overflow, full/wrap, orphan and mid-transfer reset.
module tb_cache_response_generator;

  localparam int unsigned NR = 2;
  localparam int unsigned IW = 1;
  localparam int unsigned DW = 512;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          req_issue_valid = 1'b0;
  logic [IW-1:0] req_issue_id = '0;
  logic          cache_resp_valid = 1'b0;
  logic [DW-1:0] cache_resp_rdata = '0;
  logic          cache_resp_ready;
  logic [NR-1:0] mem_resp_valid;
  logic [DW-1:0] mem_resp_rdata;
  logic [NR-1:0] mem_resp_ready = '0;
  logic          resp_credit;
  logic          tag_fifo_full;
  logic          resp_fifo_empty;
  logic          err_overflow;
  logic          err_orphan;

  cache_response_generator #(
    .NUM_MEMORY_REQUESTOR(NR), .ID_WIDTH(IW), .DATA_WIDTH(DW),
    .TAG_FIFO_DEPTH(16), .RESP_FIFO_DEPTH(16)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_issue_valid(req_issue_valid), .req_issue_id(req_issue_id),
    .cache_resp_valid(cache_resp_valid), .cache_resp_rdata(cache_resp_rdata),
    .cache_resp_ready(cache_resp_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .mem_resp_ready(mem_resp_ready), .resp_credit(resp_credit),
    .tag_fifo_full(tag_fifo_full), .resp_fifo_empty(resp_fifo_empty),
    .err_overflow(err_overflow), .err_orphan(err_orphan)
  );

  always #5 ap_clk = ~ap_clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];
  bit   sb_en = 1'b0;
  bit   prev_fire = 1'b0;

  typedef struct {
    logic        iv;
    logic        iid;
    logic        rv;
    logic [15:0] rd;
    logic [1:0]  mrdy;
    logic [1:0]  ev;
    logic [15:0] ed;
    logic        ec;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_wide(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    logic [31:0] a_lo;
    logic [31:0] e_lo;
    a_lo = act[31:0];
    e_lo = exp[31:0];
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got low word %0h, expected low word %0h (t=%0t)", name, a_lo, e_lo, $time);
    end
  endtask

  function automatic logic [DW-1:0] pat(int n);
    return {16{32'(n) ^ 32'hC0DE0000}};
  endfunction

  // Credit must follow every handshake by one cycle; deliveries are checked against the scoreboard.
  always @(negedge ap_clk) begin
    exp_t e;
    if (!ap_rst_n) begin
      prev_fire = 1'b0;
    end else begin
      chk("credit", 64'(resp_credit), 64'(prev_fire));
      prev_fire = |(mem_resp_valid & mem_resp_ready);
      if (sb_en && prev_fire) begin
        if (sb.size() == 0) begin
          chk("unexpected_delivery", 64'(mem_resp_valid), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("deliver_valid", 64'(mem_resp_valid), 64'(2'(1) << e.id));
          chk_wide("deliver_data", mem_resp_rdata, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic issue(input logic [IW-1:0] id);
    req_issue_valid = 1'b1;
    req_issue_id    = id;
    tick();
    req_issue_valid = 1'b0;
  endtask

  task automatic respond(input logic [IW-1:0] id, input logic [DW-1:0] data, input bit expect_delivery);
    int   n = 0;
    exp_t e;
    cache_resp_valid = 1'b1;
    cache_resp_rdata = data;
    @(negedge ap_clk);
    while (!cache_resp_ready && n < 300) begin
      @(negedge ap_clk);
      n++;
    end
    if (!cache_resp_ready) begin
      chk("respond_timeout", 64'(cache_resp_ready), 64'(1));
    end else if (expect_delivery) begin
      e.id   = id;
      e.data = data;
      sb.push_back(e);
    end
    tick();
    cache_resp_valid = 1'b0;
  endtask

  task automatic wait_drain(string name);
    int n = 0;
    while (!(sb.size() == 0 && resp_fifo_empty && mem_resp_valid == '0) && n < 500) begin
      @(negedge ap_clk);
      n++;
    end
    chk(name, 64'(sb.size()), 64'(0));
    tick();
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    sb.delete();
    tick();
    tick();
    ap_rst_n = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    // Cycle table: issue 0,1,0 then responses A,B,C with all readies high.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h0, 2'b11, 2'b00, 16'h0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 16'hA, 2'b11, 2'b00, 16'h0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 16'hB, 2'b11, 2'b00, 16'h0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 16'hC, 2'b11, 2'b01, 16'hA, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 16'h0, 2'b11, 2'b10, 16'hB, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 16'h0, 2'b11, 2'b01, 16'hC, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 16'h0, 2'b11, 2'b00, 16'h0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 16'h0, 2'b11, 2'b00, 16'h0, 1'b0};

    repeat (2) @(posedge ap_clk);
    #1;
    chk("rst_valid", 64'(mem_resp_valid), 64'(0));
    chk("rst_ready", 64'(cache_resp_ready), 64'(0));
    chk("rst_credit", 64'(resp_credit), 64'(0));
    chk("rst_tag_full", 64'(tag_fifo_full), 64'(0));
    chk("rst_empty", 64'(resp_fifo_empty), 64'(1));
    chk("rst_errs", 64'({err_overflow, err_orphan}), 64'(0));
    ap_rst_n = 1'b1;
    repeat (3) tick();
    chk("ready_after_rst", 64'(cache_resp_ready), 64'(1));

    for (int k = 0; k < 8; k++) begin
      @(posedge ap_clk);
      #1;
      req_issue_valid  = tbl[k].iv;
      req_issue_id     = tbl[k].iid;
      cache_resp_valid = tbl[k].rv;
      cache_resp_rdata = DW'(tbl[k].rd);
      mem_resp_ready   = tbl[k].mrdy;
      @(negedge ap_clk);
      chk($sformatf("tbl%0d_valid", k), 64'(mem_resp_valid), 64'(tbl[k].ev));
      if (tbl[k].ev != 2'b00) chk($sformatf("tbl%0d_data", k), 64'(mem_resp_rdata[15:0]), 64'(tbl[k].ed));
      chk($sformatf("tbl%0d_credit", k), 64'(resp_credit), 64'(tbl[k].ec));
    end
    chk("tbl_errs", 64'({err_overflow, err_orphan}), 64'(0));
    chk("tbl_empty", 64'(resp_fifo_empty), 64'(1));
    tick();

    // Requestor 1 stalls at the head; requestor 0's response must wait behind it.
    sb_en = 1'b1;
    mem_resp_ready = 2'b01;
    issue(1'b1);
    issue(1'b0);
    respond(1'b1, pat(11), 1'b1);
    respond(1'b0, pat(10), 1'b1);
    begin
      int n = 0;
      while (mem_resp_valid != 2'b10 && n < 50) begin
        @(negedge ap_clk);
        n++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      chk("stall_valid", 64'(mem_resp_valid), 64'(2'b10));
      chk_wide("stall_data", mem_resp_rdata, pat(11));
    end
    tick();
    mem_resp_ready = 2'b11;
    wait_drain("stall_drain");

    // Fill the response buffer with readies low, free one slot, then wrap through 32 responses.
    mem_resp_ready = 2'b00;
    for (int i = 0; i < 17; i++) begin
      issue(IW'(i % 2));
      respond(IW'(i % 2), pat(100 + i), 1'b1);
    end
    @(negedge ap_clk);
    chk("full_ready_low", 64'(cache_resp_ready), 64'(0));
    chk("full_not_empty", 64'(resp_fifo_empty), 64'(0));
    mem_resp_ready = 2'b01;
    tick();
    mem_resp_ready = 2'b00;
    @(negedge ap_clk);
    chk("pop_ready_high", 64'(cache_resp_ready), 64'(1));
    tick();
    mem_resp_ready = 2'b11;
    for (int i = 17; i < 32; i++) begin
      issue(IW'(i % 2));
      respond(IW'(i % 2), pat(100 + i), 1'b1);
    end
    wait_drain("wrap_drain");

    // 17 issues without responses: full after 16, overflow after the 17th.
    for (int i = 0; i < 17; i++) begin
      req_issue_valid = 1'b1;
      req_issue_id    = IW'(i % 2);
      tick();
      if (i == 14) chk("tag_not_full_15", 64'(tag_fifo_full), 64'(0));
      if (i == 15) begin
        chk("tag_full_16", 64'(tag_fifo_full), 64'(1));
        chk("no_overflow_16", 64'(err_overflow), 64'(0));
      end
    end
    req_issue_valid = 1'b0;
    chk("overflow_17", 64'(err_overflow), 64'(1));
    for (int i = 0; i < 16; i++) respond(IW'(i % 2), pat(200 + i), 1'b1);
    wait_drain("overflow_drain");
    chk("overflow_tag_not_full", 64'(tag_fifo_full), 64'(0));
    chk("overflow_sticky", 64'({err_overflow, err_orphan}), 64'(2'b10));

    // Orphan response: dropped, flagged, nothing delivered.
    do_reset();
    chk("errs_cleared", 64'({err_overflow, err_orphan}), 64'(0));
    respond(1'b0, pat(300), 1'b0);
    chk("orphan_flag", 64'({err_overflow, err_orphan}), 64'(2'b01));
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      chk("orphan_no_valid", 64'(mem_resp_valid), 64'(0));
      chk("orphan_empty", 64'(resp_fifo_empty), 64'(1));
    end
    tick();

    // Reset while sending with five responses buffered.
    do_reset();
    mem_resp_ready = 2'b00;
    for (int i = 0; i < 6; i++) issue(IW'(i % 2));
    for (int i = 0; i < 6; i++) respond(IW'(i % 2), pat(400 + i), 1'b1);
    tick();
    chk("pre_rst_sending", 64'(mem_resp_valid), 64'(2'b01));
    #3;
    ap_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(mem_resp_valid), 64'(0));
    chk_wide("mid_rst_data", mem_resp_rdata, '0);
    chk("mid_rst_ready", 64'(cache_resp_ready), 64'(0));
    chk("mid_rst_empty", 64'(resp_fifo_empty), 64'(1));
    chk("mid_rst_credit", 64'(resp_credit), 64'(0));
    sb.delete();
    tick();
    tick();
    ap_rst_n = 1'b1;
    repeat (3) tick();
    mem_resp_ready = 2'b11;
    issue(1'b1);
    respond(1'b1, pat(500), 1'b1);
    wait_drain("post_rst_drain");
    chk("post_rst_errs", 64'({err_overflow, err_orphan}), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
